// File: rtl/serial_in_if.sv
// ============================================================================
//  serial_in_if
//  Status link and parallel alarm-state bundle for the serial_in receiver.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_in_if #(
    parameter int DATA_W = 4
);
    logic              status_send;
    logic              status_out;
    logic [DATA_W-1:0] state_out;
    logic              state_valid;
    logic              state_changed;
    logic              frame_err;
    logic              busy;

    modport master (
        output status_send,
        output status_out,
        input  state_out,
        input  state_valid,
        input  state_changed,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  status_send,
        input  status_out,
        output state_out,
        output state_valid,
        output state_changed,
        output frame_err,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/serial_in.sv
// ============================================================================
//  serial_in
//  Deserializes MSB-first status frames into a registered alarm state word.
//  Optional macro SERIAL_IN_SYNC_EN adds 2-flop input synchronizers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module serial_in #(
    parameter int DATA_W = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    serial_in_if.slave   link
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic send_in;
    logic data_in;

`ifdef SERIAL_IN_SYNC_EN
    logic [1:0] send_sync_q;
    logic [1:0] data_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_sync_q <= 2'b00;
            data_sync_q <= 2'b00;
        end else begin
            send_sync_q <= {send_sync_q[0], link.status_send};
            data_sync_q <= {data_sync_q[0], link.status_out};
        end
    end

    assign send_in = send_sync_q[1];
    assign data_in = data_sync_q[1];
`else
    assign send_in = link.status_send;
    assign data_in = link.status_out;
`endif

    state_t              state_q, state_d;
    // Holds only the bits received so far; the final bit joins straight from data_in.
    logic [DATA_W-2:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   state_out_q, state_out_d;
    logic                valid_q, valid_d;
    logic                changed_q, changed_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                first_q, first_d;
    logic [DATA_W-1:0]   word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            state_out_q <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            state_out_q <= state_out_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        word        = {shreg_q, data_in};
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        state_out_d = state_out_q;
        valid_d     = 1'b0;
        changed_d   = 1'b0;
        err_d       = 1'b0;
        first_d     = first_q;

        case (state_q)
            IDLE: begin
                if (send_in) begin
                    shreg_d = word[DATA_W-2:0];
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (send_in) begin
                    shreg_d = word[DATA_W-2:0];
                    if (cnt_q == LAST_CNT) begin
                        state_out_d = word;
                        valid_d     = 1'b1;
                        changed_d   = (word != state_out_q) || first_q;
                        first_d     = 1'b0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Truncated frame: drop the partial word, keep the last good state.
                    err_d   = 1'b1;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

    assign link.state_out     = state_out_q;
    assign link.state_valid   = valid_q;
    assign link.state_changed = changed_q;
    assign link.frame_err     = err_q;
    assign link.busy          = busy_q;

endmodule

`default_nettype wire

// File: doc/serial_in.md
Name: serial_in

Overview:
- Receive side of the alarm-status serial link; sits directly downstream of the status serializer.
- Frame format on the link:
  - status_send is high for exactly DATA_W consecutive clocks.
  - status_out carries one data bit per clock, MSB first.
  - The MSB is valid in the first clock that status_send is high.
- Reassembles the word, presents it as a registered parallel state with a one-cycle valid strobe, and flags changed states and truncated frames for the alarm controller.

Parameters:
- DATA_W, 4, bits per frame (alarm state width).

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- status_send  in  1  frame-active strobe from the serializer.
- status_out  in  1  serial data from the serializer, MSB first.
- state_out  out  DATA_W  last complete received word; holds between frames.
- state_valid  out  1  one-clock pulse when state_out is updated.
- state_changed  out  1  one-clock pulse, coincident with state_valid, when the new word differs from the previous one.
- frame_err  out  1  one-clock pulse when a frame ends before DATA_W bits arrive.
- busy  out  1  high while a frame is being shifted in.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State machine goes to IDLE.
  - Shift register, bit counter and state_out clear to 0.
  - state_valid, state_changed, frame_err and busy clear to 0.
  - first_word flag is set.
  - A frame in progress is discarded; there is no partial commit.
- All outputs are registered. Strobes are high for exactly one clock, otherwise 0.
- IDLE:
  - status_send=0: stay in IDLE.
  - status_send=1: shreg <= {shreg[DATA_W-2:0], status_out}, cnt <= 1, go to SHIFT.
- SHIFT, status_send=1:
  - Shift status_out in; cnt++.
  - When this edge samples bit DATA_W (cnt was DATA_W-1), commit and go to IDLE.
- SHIFT, status_send=0: frame_err pulses next cycle, shreg is discarded, go to IDLE, state_out is unchanged.
- Commit:
  - state_out <= assembled word; state_valid=1 in the following cycle.
  - state_changed=1 if (word != state_out) or first_word; first_word then clears.
- Latency: if the first edge sampling status_send=1 is edge k, state_valid is high in the cycle after edge k+DATA_W-1.
- Back-to-back frames:
  - If status_send is still high at the edge after a commit, IDLE treats that edge as bit 1 of a new frame. There are no lost cycles.
  - A continuously high status_send therefore yields a commit every DATA_W clocks.
- busy = 1 in SHIFT, and also in the clock following the IDLE->SHIFT edge. It drops in the cycle state_valid rises unless a new frame starts on that edge.
- frame_err and state_valid are never asserted in the same cycle.
- status_out is ignored while status_send=0.

Optional Feature:
- Macro: SERIAL_IN_SYNC_EN.
- Defined:
  - status_send and status_out each pass through a 2-flop synchronizer, reset to 0, before the FSM.
  - Every latency above grows by exactly 2 clocks.
  - Use this when the link comes from another clock domain or board.
- Undefined: inputs feed the FSM directly, with latency as specified.

Test Plan:
- Reset, then one frame of 4'b1010 (send high 4 clocks, bits 1,0,1,0) -> state_out=4'hA, state_valid and state_changed pulse once, 1 clock after the 4th sampling edge; frame_err=0.
- Frame 4'hA, idle 3 clocks, frame 4'hA -> second commit has state_valid=1, state_changed=0; state_out stays 4'hA.
- Back-to-back frames 4'h3 then 4'hC with status_send high for 8 consecutive clocks -> two state_valid pulses exactly 4 clocks apart, state_out 4'h3 then 4'hC, state_changed=1 both times.
- status_send high for only 2 clocks (bits 1,1) -> frame_err pulse one clock after send falls; state_out keeps its previous value (0 after reset); no state_valid.
- rst_n pulsed low after 2 bits of a 4'hF frame, then a full frame of 4'h5 -> no commit of the partial frame; commit of 4'h5 with state_changed=1 (first word after reset).
- With SERIAL_IN_SYNC_EN defined, repeat the first scenario -> identical values, with the state_valid pulse delayed by exactly 2 clocks.
